// File: rtl/ivs_dma_rd_ctrl.sv
// Read-job controller: splits one job into chunk requests for the DMA read splitter and
// streams the returned words out through a credit-protected FIFO.
module ivs_dma_rd_ctrl #(
  parameter int unsigned BDWD        = 64,
  parameter int unsigned CHUNK_BYTES = 128,
  parameter int unsigned FIFO_DEPTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sw_rst,
  input  logic            job_start,
  input  logic [31:0]     job_base,
  input  logic [15:0]     job_bytes,
  output logic            job_busy,
  output logic            job_done,
  output logic            job_abort,
  output logic            ori_req,
  output logic [31:0]     ori_base,
  output logic [7:0]      ori_bytes,
  input  logic            ori_ack,
  input  logic [BDWD-1:0] ori_rdata,
  input  logic            ori_valid,
  input  logic            ori_rlast,
  output logic [BDWD-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [3:0]      out_nbytes,
  output logic            err_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHK   = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [31:0]     base_q;
  logic [15:0]     remaining_q;
  logic [12:0]     last_idx_q;
  logic [3:0]      last_nb_q;
  logic [12:0]     pop_cnt_q;
  logic [CW-1:0]   credit_q, credit_d;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [BDWD-1:0] mem_q [FIFO_DEPTH];
  logic            abort_q, abort_d;
  logic            err_q, err_d;

  logic [7:0]      chunk;
  logic [CW-1:0]   words;
  logic            busy, abort_now, req_ack, accept, push, pop, full, ovf, drain_empty;
  logic            job_accept;

  assign chunk = (remaining_q >= 16'(CHUNK_BYTES)) ? 8'(CHUNK_BYTES) : remaining_q[7:0];
  assign words = CW'((9'(chunk) + 9'd7) >> 3);

  assign busy       = (state_q == CHK) || (state_q == REQ) || (state_q == DATA) ||
                      (state_q == DRAIN);
  assign abort_now  = sw_rst && busy;
  assign job_accept = (state_q == IDLE) && job_start;
  assign req_ack    = (state_q == REQ) && ori_ack;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = out_valid && out_ready && !abort_now;
  // Words belonging to an aborted chunk are swallowed without flagging an error.
  assign accept    = ori_valid && (state_q == DATA) && !abort_q && !abort_now;
  assign push      = accept && !full;
  assign ovf       = ori_valid && (((state_q != DATA) && (state_q != DRAIN)) || (accept && full));
  assign drain_empty = (count_q == '0) || ((count_q == CW'(1)) && pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_start) state_d = (job_bytes != 16'd0) ? CHK : DONE;
      CHK: begin
        if (abort_now)              state_d = DONE;
        else if (credit_q >= words) state_d = REQ;
      end
      REQ: begin
        if (ori_ack)        state_d = DATA;
        else if (abort_now) state_d = DONE;
      end
      DATA: begin
        if (ori_valid && ori_rlast) begin
          if (abort_q || abort_now)     state_d = DONE;
          else if (remaining_q == '0)   state_d = DRAIN;
          else                          state_d = CHK;
        end
      end
      DRAIN:   if (abort_now || drain_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q + CW'(pop) - (req_ack ? words : '0);
    if (abort_now) credit_d = DEPTH_C;
    abort_d = abort_q;
    if (state_q == DONE) abort_d = 1'b0;
    else if (abort_now)  abort_d = 1'b1;
    err_d = (err_q && !job_accept) || ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      last_idx_q  <= '0;
      last_nb_q   <= '0;
      pop_cnt_q   <= '0;
      credit_q    <= DEPTH_C;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      if (job_accept) begin
        base_q      <= job_base;
        remaining_q <= job_bytes;
        // Index of the final word; 13 bits covers ceil(65535/8)-1.
        last_idx_q  <= 13'((job_bytes - 16'd1) >> 3);
        last_nb_q   <= (job_bytes[2:0] == 3'd0) ? 4'd8 : {1'b0, job_bytes[2:0]};
      end else if (req_ack) begin
        base_q      <= base_q + 32'(chunk);
        remaining_q <= remaining_q - 16'(chunk);
      end
      if (job_accept) pop_cnt_q <= '0;
      else if (pop)   pop_cnt_q <= pop_cnt_q + 13'd1;
      if (abort_now) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ori_rdata;
  end

  assign job_busy   = busy;
  assign job_done   = (state_q == DONE);
  assign job_abort  = (state_q == DONE) && abort_q;
  assign ori_req    = (state_q == REQ);
  assign ori_base   = (state_q == REQ) ? base_q : '0;
  assign ori_bytes  = (state_q == REQ) ? chunk : '0;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last   = out_valid && (pop_cnt_q == last_idx_q);
  assign out_nbytes = !out_valid ? 4'd0 : (out_last ? last_nb_q : 4'd8);
  assign err_ovf    = err_q;

endmodule

// File: tb/tb_ivs_dma_rd_ctrl.sv
// Randomized bench for ivs_dma_rd_ctrl: behavioural splitter, stream consumer and a
// queue-based model of the expected requests and output words.
module tb_ivs_dma_rd_ctrl;

  localparam int CHUNK = 128;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst, sw_rst, job_start;
  logic [31:0] job_base;
  logic [15:0] job_bytes;
  logic        job_busy, job_done, job_abort;
  logic        ori_req, ori_ack, ori_valid, ori_rlast;
  logic [31:0] ori_base;
  logic [7:0]  ori_bytes;
  logic [63:0] ori_rdata, out_data;
  logic        out_valid, out_ready, out_last, err_ovf;
  logic [3:0]  out_nbytes;

  ivs_dma_rd_ctrl #(
    .BDWD        (64),
    .CHUNK_BYTES (CHUNK),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .job_start  (job_start),
    .job_base   (job_base),
    .job_bytes  (job_bytes),
    .job_busy   (job_busy),
    .job_done   (job_done),
    .job_abort  (job_abort),
    .ori_req    (ori_req),
    .ori_base   (ori_base),
    .ori_bytes  (ori_bytes),
    .ori_ack    (ori_ack),
    .ori_rdata  (ori_rdata),
    .ori_valid  (ori_valid),
    .ori_rlast  (ori_rlast),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_nbytes (out_nbytes),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  logic [39:0] req_exp[$];
  int ready_mode = 1;
  int ack_delay  = -1;
  bit aborted    = 1'b0;
  int spur_req   = 0;
  int req_count  = 0;
  int chunk_words_sent = 0;
  int req_hi_cycles    = 0;
  int pops_total    = 0;
  int pops_at_start = 0;
  int last_pop_cyc  = -10;
  int cur_bytes     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Splitter model: acks after a programmable delay, then returns ceil(bytes/8) words.
  initial begin
    int wait_cnt, spl_words, spur_done;
    bit in_wait;
    logic [31:0] hb;
    logic [7:0]  hn;
    logic [39:0] e;
    ori_ack = 0; ori_valid = 0; ori_rlast = 0; ori_rdata = '0;
    wait_cnt = 0; spl_words = 0; spur_done = 0; in_wait = 0; hb = '0; hn = '0;
    forever begin
      @(negedge clk);
      ori_ack = 0; ori_valid = 0; ori_rlast = 0;
      if (rst) continue;
      if (ori_req) req_hi_cycles++;
      if (spur_req != spur_done) begin
        spur_done = spur_req;
        ori_valid = 1; ori_rdata = {$urandom, $urandom};
      end else if (spl_words != 0) begin
        check_eq("one_outstanding", 64'(ori_req), 64'd0);
        if ($urandom_range(0, 3) != 0) begin
          ori_valid = 1; ori_rdata = {$urandom, $urandom};
          spl_words--; chunk_words_sent++;
          ori_rlast = (spl_words == 0);
          if (!aborted) exp_q.push_back(ori_rdata);
        end
      end else if (ori_req) begin
        if (!in_wait) begin
          in_wait = 1; hb = ori_base; hn = ori_bytes;
          wait_cnt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        end else begin
          check_eq("req_base_stable", 64'(ori_base), 64'(hb));
          check_eq("req_bytes_stable", 64'(ori_bytes), 64'(hn));
        end
        if (wait_cnt == 0) begin
          ori_ack = 1; in_wait = 0; req_count++; chunk_words_sent = 0;
          spl_words = (int'(ori_bytes) + 7) / 8;
          if (req_exp.size() == 0) check_eq("req_unexpected", 64'(ori_req), 64'd0);
          else begin
            e = req_exp.pop_front();
            check_eq("req_base", 64'(ori_base), 64'(e[39:8]));
            check_eq("req_bytes", 64'(ori_bytes), 64'(e[7:0]));
          end
        end else wait_cnt--;
      end else in_wait = 0;
    end
  end

  // Stream consumer and output checker.
  initial begin
    int idx, total;
    logic [63:0] e;
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin out_ready = 0; continue; end
      if (ready_mode == 0)      out_ready = 0;
      else if (ready_mode == 1) out_ready = 1;
      else                      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        idx   = pops_total - pops_at_start;
        total = (cur_bytes + 7) / 8;
        if (exp_q.size() == 0) check_eq("pop_unexpected", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e);
          check_eq("out_last", 64'(out_last), 64'(idx == total - 1));
          check_eq("out_nbytes", 64'(out_nbytes),
                   64'((idx == total - 1) ? ((cur_bytes - 1) % 8) + 1 : 8));
        end
        pops_total++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic start_job(input logic [31:0] b, input int n);
    logic [31:0] a;
    int rem, c;
    @(negedge clk);
    a = b; rem = n;
    while (rem > 0) begin
      c = (rem > CHUNK) ? CHUNK : rem;
      req_exp.push_back({a, 8'(c)});
      a = a + 32'(c);
      rem -= c;
    end
    cur_bytes = n; pops_at_start = pops_total; aborted = 0;
    job_base = b; job_bytes = 16'(n); job_start = 1;
    @(negedge clk);
    job_start = 0;
    check_eq("busy_after_start", 64'(job_busy), 64'(n != 0));
  endtask

  task automatic wait_done(input string tag, input bit exp_abort);
    bit got;
    got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      if (job_done) got = 1;
      else @(negedge clk);
    end
    check_eq({tag, "_done"}, 64'(got), 64'd1);
    if (got) begin
      check_eq({tag, "_abort"}, 64'(job_abort), 64'(exp_abort));
      check_eq({tag, "_busy_low"}, 64'(job_busy), 64'd0);
      if (!exp_abort) begin
        if (cur_bytes != 0) check_eq({tag, "_done_lat"}, 64'(cyc - last_pop_cyc), 64'd1);
        check_eq({tag, "_words"}, 64'(pops_total - pops_at_start), 64'((cur_bytes + 7) / 8));
        check_eq({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_req_left"}, 64'(req_exp.size()), 64'd0);
        check_eq({tag, "_err"}, 64'(err_ovf), 64'd0);
      end
    end
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(job_done), 64'd0);
  endtask

  initial begin
    int rq0, hi0, n;
    bit reached;
    int lens[6];
    lens = '{1, 7, 8, 128, 129, 256};
    rst = 1; sw_rst = 0; job_start = 0; job_base = '0; job_bytes = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(job_busy), 64'd0);
    check_eq("rst_done", 64'(job_done), 64'd0);
    check_eq("rst_abort", 64'(job_abort), 64'd0);
    check_eq("rst_req", 64'(ori_req), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", out_data, 64'd0);
    check_eq("rst_nbytes", 64'(out_nbytes), 64'd0);
    check_eq("rst_err", 64'(err_ovf), 64'd0);
    rst = 0;

    ready_mode = 1; ack_delay = 0;
    start_job(32'h1000, 40);
    wait_done("single", 0);

    ready_mode = 2; ack_delay = -1;
    start_job(32'h2003, 300);
    wait_done("multi", 0);

    // Consumer stalled: credit admits only DEPTH words worth of chunks.
    ready_mode = 0;
    rq0 = req_count;
    start_job(32'h4000, 512);
    repeat (300) @(negedge clk);
    check_eq("bp_reqs", 64'(req_count - rq0), 64'(DEPTH / (CHUNK / 8)));
    check_eq("bp_req_low", 64'(ori_req), 64'd0);
    check_eq("bp_busy", 64'(job_busy), 64'd1);
    check_eq("bp_valid", 64'(out_valid), 64'd1);
    ready_mode = 2;
    wait_done("bp", 0);

    hi0 = req_hi_cycles;
    start_job(32'h5000, 0);
    wait_done("zero", 0);
    check_eq("zero_no_req", 64'(req_hi_cycles - hi0), 64'd0);

    ack_delay = 5; ready_mode = 1;
    hi0 = req_hi_cycles;
    start_job(32'h6000, 8);
    wait_done("ack_lat", 0);
    check_eq("ack_lat_hold", 64'(req_hi_cycles - hi0), 64'd6);

    // Abort part-way through the second chunk.
    ack_delay = -1; ready_mode = 0;
    rq0 = req_count;
    start_job(32'h7000, 384);
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if ((req_count - rq0 >= 2) && (chunk_words_sent >= 3)) reached = 1;
      else @(negedge clk);
    end
    check_eq("abort_reach", 64'(reached), 64'd1);
    sw_rst = 1; aborted = 1;
    hi0 = req_hi_cycles;
    @(negedge clk);
    sw_rst = 0;
    check_eq("abort_flush", 64'(out_valid), 64'd0);
    wait_done("abort", 1);
    check_eq("abort_no_req", 64'(req_hi_cycles - hi0), 64'd0);
    check_eq("abort_empty", 64'(out_valid), 64'd0);
    check_eq("abort_err", 64'(err_ovf), 64'd0);
    exp_q.delete();
    req_exp.delete();
    ready_mode = 2;
    start_job($urandom, 200);
    wait_done("post_abort", 0);

    spur_req++;
    repeat (3) @(negedge clk);
    check_eq("spur_err", 64'(err_ovf), 64'd1);
    check_eq("spur_fifo", 64'(out_valid), 64'd0);
    start_job(32'h8000, 64);
    check_eq("spur_clear", 64'(err_ovf), 64'd0);
    wait_done("spur_job", 0);

    start_job(32'hFFFF_FFC0, 200);
    wait_done("wrap", 0);

    foreach (lens[k]) begin
      start_job($urandom, lens[k]);
      wait_done("len", 0);
    end

    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, 700));
      start_job($urandom, n);
      wait_done("rand", 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
